// File: rtl/add_sub_seq.sv
// Multi-cycle signed add/subtract, W bits per cycle; ADDSUB_SAT_EN adds a saturating-clamp 'sat' input.
// Latency: out_valid rises N/W cycles after the accept edge; one operation in flight at a time.
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE.
module add_sub_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
`ifdef ADDSUB_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   s,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         busy
);

    localparam int C  = N / W;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  bx_sh;
    logic [N-1:0]  sum_r;
    logic          a_msb;
    logic          bx_msb;
    logic          carry;
    logic [CW-1:0] cnt;
`ifdef ADDSUB_SAT_EN
    logic          sat_r;
`endif

    logic [W:0]    chunk;
    logic [N-1:0]  sum_nxt;
    logic          ovf_nxt;
    logic          s_top;
    logic [N:0]    res_nxt;

    // Operands shift right one chunk per cycle; the sum fills in from the top.
    always_comb begin
        chunk   = {1'b0, a_sh[W-1:0]} + {1'b0, bx_sh[W-1:0]} + {{W{1'b0}}, carry};
        sum_nxt = (sum_r >> W) | (N'(chunk[W-1:0]) << (N - W));
        // carry into the MSB recovered from the MSB sum bit and its operands
        ovf_nxt = (sum_nxt[N-1] ^ a_msb ^ bx_msb) ^ chunk[W];
        s_top   = a_msb ^ bx_msb ^ chunk[W];
        res_nxt = {s_top, sum_nxt};
`ifdef ADDSUB_SAT_EN
        if (sat_r && ovf_nxt)
            res_nxt = s_top ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            bx_sh  <= '0;
            sum_r  <= '0;
            a_msb  <= 1'b0;
            bx_msb <= 1'b0;
            carry  <= 1'b0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        bx_sh  <= b ^ {N{k}};
                        a_msb  <= a[N-1];
                        bx_msb <= b[N-1] ^ k;
                        carry  <= k;
                        cnt    <= '0;
                        sum_r  <= '0;
`ifdef ADDSUB_SAT_EN
                        sat_r  <= sat;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_sh  <= a_sh >> W;
                    bx_sh <= bx_sh >> W;
                    sum_r <= sum_nxt;
                    carry <= chunk[W];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(C - 1)) begin
                        s     <= res_nxt;
                        cout  <= chunk[W];
                        ovf   <= ovf_nxt;
                        zero  <= (sum_nxt == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add_sub_seq.sv
// Randomized bench for add_sub_seq at (N,W) = (32,8), (64,16), (8,8) against an exact-integer model.
// Also covers output backpressure and reset in the middle of CALC.
module tb_add_sub_seq;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        iv32, ir32, k32, ov32, or32, co32, of32, zr32, bz32;
    logic [31:0] a32, b32;
    logic [32:0] s32;
    logic        iv64, ir64, k64, ov64, or64, co64, of64, zr64, bz64;
    logic [63:0] a64, b64;
    logic [64:0] s64;
    logic        iv8, ir8, k8, ov8, or8, co8, of8, zr8, bz8;
    logic [7:0]  a8, b8;
    logic [8:0]  s8;
`ifdef ADDSUB_SAT_EN
    logic        sat32, sat64, sat8;
`endif

    add_sub_seq #(.N(32), .W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .k(k32),
`ifdef ADDSUB_SAT_EN
        .sat(sat32),
`endif
        .out_valid(ov32), .out_ready(or32), .s(s32), .cout(co32), .ovf(of32), .zero(zr32), .busy(bz32));

    add_sub_seq #(.N(64), .W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .k(k64),
`ifdef ADDSUB_SAT_EN
        .sat(sat64),
`endif
        .out_valid(ov64), .out_ready(or64), .s(s64), .cout(co64), .ovf(of64), .zero(zr64), .busy(bz64));

    add_sub_seq #(.N(8), .W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .k(k8),
`ifdef ADDSUB_SAT_EN
        .sat(sat8),
`endif
        .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(of8), .zero(zr8), .busy(bz8));

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nof(input int sel);
        return (sel == 0) ? 32 : (sel == 1) ? 64 : 8;
    endfunction

    function automatic int wof(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 8;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [63:0] av, input logic [63:0] bv,
                          input logic kv, input logic sv);
        case (sel)
            0: begin iv32 = v; a32 = av[31:0]; b32 = bv[31:0]; k32 = kv; end
            1: begin iv64 = v; a64 = av;       b64 = bv;       k64 = kv; end
            default: begin iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; k8 = kv; end
        endcase
`ifdef ADDSUB_SAT_EN
        case (sel)
            0: sat32 = sv;
            1: sat64 = sv;
            default: sat8 = sv;
        endcase
`endif
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: or32 = v;
            1: or64 = v;
            default: or8 = v;
        endcase
    endtask

    task automatic rd(input int sel, output logic ov, output logic ir, output logic bz, output logic co,
                      output logic of, output logic zr, output logic [64:0] sv);
        case (sel)
            0: begin ov = ov32; ir = ir32; bz = bz32; co = co32; of = of32; zr = zr32; sv = 65'(s32); end
            1: begin ov = ov64; ir = ir64; bz = bz64; co = co64; of = of64; zr = zr64; sv = s64; end
            default: begin ov = ov8; ir = ir8; bz = bz8; co = co8; of = of8; zr = zr8; sv = 65'(s8); end
        endcase
    endtask

    // Exact-integer reference: sign-extend, add/sub in 66 bits, derive flags from the true value.
    task automatic model(input int n, input logic [63:0] av, input logic [63:0] bv, input logic kv,
                         input logic sv, output logic [64:0] es, output logic ec, output logic eo,
                         output logic ez);
        logic [63:0]        ta, tb;
        logic signed [65:0] sa, sb, r, lim;
        logic [65:0]        mask_n, ua, ub;
        ta     = av << (64 - n);
        tb     = bv << (64 - n);
        sa     = $signed({{2{ta[63]}}, ta}) >>> (64 - n);
        sb     = $signed({{2{tb[63]}}, tb}) >>> (64 - n);
        r      = kv ? (sa - sb) : (sa + sb);
        mask_n = (66'd1 << n) - 66'd1;
        ua     = {2'b00, av} & mask_n;
        ub     = {2'b00, bv} & mask_n;
        lim    = 66'sd1 <<< (n - 1);
        es     = 65'(r & ((66'd1 << (n + 1)) - 66'd1));
        eo     = (r >= lim) || (r < -lim);
        ec     = kv ? (ua >= ub) : (((ua + ub) >> n) != 66'd0);
        ez     = ((r & mask_n) == 66'd0);
        if (sv && eo)
            es = (r < 0) ? 65'((66'd3 << (n - 1))) : 65'((66'd1 << (n - 1)) - 66'd1);
    endtask

    task automatic do_op(input int sel, input logic [63:0] av, input logic [63:0] bv,
                         input logic kv, input logic sv);
        int n, lat;
        logic ov, ir, bz, co, of, zr, ec, eo, ez;
        logic [64:0] so, es;
        n = nof(sel);
        model(n, av, bv, kv, sv, es, ec, eo, ez);
        @(negedge clk);
        rd(sel, ov, ir, bz, co, of, zr, so);
        chk($sformatf("in_ready_idle/%0d", n), ir, 1);
        set_in(sel, 1'b1, av, bv, kv, sv);
        @(posedge clk);
        #1 set_in(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
        @(negedge clk);
        rd(sel, ov, ir, bz, co, of, zr, so);
        chk($sformatf("calc_busy/%0d", n), {bz, ir}, 2'b10);
        lat = 0;
        while (!ov && lat < 64) begin
            lat++;
            @(negedge clk);
            rd(sel, ov, ir, bz, co, of, zr, so);
        end
        chk($sformatf("latency/%0d", n), lat, n / wof(sel));
        chk($sformatf("s/%0d a=%h b=%h k=%b", n, av, bv, kv), so, es);
        chk($sformatf("flags c,v,z/%0d a=%h b=%h k=%b", n, av, bv, kv), {co, of, zr}, {ec, eo, ez});
        @(negedge clk);
        rd(sel, ov, ir, bz, co, of, zr, so);
        chk($sformatf("post_hs ov,ir/%0d", n), {ov, ir}, 2'b01);
        chk($sformatf("s_retained/%0d", n), so, es);
    endtask

    function automatic logic [63:0] pick(input int n);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'd1 << (n - 1);
            2: v = (64'd1 << (n - 1)) - 64'd1;
            3: v = '1;
            default: v = {$urandom, $urandom};
        endcase
        return (n == 64) ? v : (v & ((64'd1 << n) - 64'd1));
    endfunction

    initial begin
        logic ov, ir, bz, co, of, zr, ec, eo, ez, seen;
        logic [64:0] so, es;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            set_ordy(i, 1'b1);
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            rd(i, ov, ir, bz, co, of, zr, so);
            chk($sformatf("reset ov,ir,bz,c,v,z/%0d", nof(i)), {ov, ir, bz, co, of, zr}, 6'b010000);
            chk($sformatf("reset s/%0d", nof(i)), so, 65'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 64'd5, 64'd3, 1'b0, 1'b0);
        do_op(0, 64'd3, 64'd5, 1'b1, 1'b0);
        do_op(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
        do_op(0, 64'h8000_0000, 64'd1, 1'b1, 1'b0);
        do_op(0, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b0);
        if (SAT_ON) begin
            do_op(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b1);
            do_op(0, 64'h8000_0000, 64'd1, 1'b1, 1'b1);
            do_op(2, 64'h80, 64'h7F, 1'b1, 1'b1);
        end
        do_op(2, 64'h7F, 64'd1, 1'b0, 1'b0);
        do_op(2, 64'h80, 64'd1, 1'b1, 1'b0);
        do_op(2, 64'h00, 64'h00, 1'b1, 1'b0);
        do_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0);

        for (int i = 0; i < 50; i++) begin
            do_op(1, pick(64), pick(64), 1'($urandom), SAT_ON & 1'($urandom));
            do_op(2, pick(8), pick(8), 1'($urandom), SAT_ON & 1'($urandom));
        end
        for (int i = 0; i < 20; i++)
            do_op(0, pick(32), pick(32), 1'($urandom), SAT_ON & 1'($urandom));

        // Backpressure: hold out_ready low, offer new operands every cycle.
        model(32, 64'h0000_1234, 64'hFFFF_0000, 1'b0, 1'b0, es, ec, eo, ez);
        set_ordy(0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b1, 64'h0000_1234, 64'hFFFF_0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = ov32;
        end
        chk("bp out_valid seen", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rd(0, ov, ir, bz, co, of, zr, so);
            chk($sformatf("bp hold ov,ir,bz #%0d", i), {ov, ir, bz}, 3'b101);
            chk($sformatf("bp hold s #%0d", i), so, es);
            chk($sformatf("bp hold flags #%0d", i), {co, of, zr}, {ec, eo, ez});
            set_in(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
            @(negedge clk);
        end
        set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        set_ordy(0, 1'b1);
        @(negedge clk);
        rd(0, ov, ir, bz, co, of, zr, so);
        chk("bp release ov,ir", {ov, ir}, 2'b01);
        chk("bp release s", so, es);
        do_op(0, 64'hDEAD_BEEF, 64'h0BAD_F00D, 1'b1, 1'b0);

        // Reset during the second CALC cycle abandons the operation.
        @(negedge clk);
        set_in(0, 1'b1, 64'h0000_0100, 64'h0000_0200, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rd(0, ov, ir, bz, co, of, zr, so);
        chk("midcalc rst ov,ir,bz,c,v,z", {ov, ir, bz, co, of, zr}, 6'b010000);
        chk("midcalc rst s", so, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | ov32;
        end
        chk("no result after rst", seen, 1'b0);
        do_op(0, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
